axis_width_upsizer: RTL and testbench

Write-clock-domain AXI-Stream width upsizer that packs RATIO narrow input beats into one wide beat, ahead of the async AXIS FIFO. Its wide master port drives the FIFO slave port (s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready) directly. This lets the FIFO cross into a slower read clock at equal bandwidth. Packets ending mid-word are flushed early with partial tkeep.

---
 rtl/axis_pkg.sv | 29 ++
 rtl/axis_width_upsizer_if.sv | 18 +
 rtl/axis_width_upsizer.sv | 119 +++++++++++
 tb/tb_axis_width_upsizer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: clog2, keep-width derivation, lane-index width
// and the one-entry output register state encoding.
package axis_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    // A one-lane accumulator still needs a 1-bit index to stay a legal vector.
    function automatic int lane_width(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

    localparam int DEFAULT_RATIO  = 4;
    localparam int DEFAULT_LANE_W = lane_width(DEFAULT_RATIO);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/axis_width_upsizer_if.sv
// AXI-Stream bus bundle used for both the narrow and the wide side of the upsizer.
interface axis_width_upsizer_if #(
    parameter int DATA_W = 8
);
    import axis_pkg::*;

    localparam int KEEP_W = keep_width(DATA_W);

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXIS beats into one wide registered beat, flushing early on tlast.
// Optional AXIS_WIDTH_UPSIZER_PKT_CNT_EN adds a 32-bit wrapping packet counter output.
module axis_width_upsizer
    import axis_pkg::*;
#(
    parameter int S_DATA_WIDTH = 8,
    parameter int RATIO        = 4
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    axis_width_upsizer_if.slave    s,
`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
    output logic [31:0]            pkt_cnt,
`endif
    axis_width_upsizer_if.master   m
);

    localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
    localparam int S_KEEP_W     = keep_width(S_DATA_WIDTH);
    localparam int M_KEEP_W     = keep_width(M_DATA_WIDTH);
    localparam int LANE_W       = lane_width(RATIO);

    logic [LANE_W-1:0]                     lane;
    logic [RATIO-1:0][S_DATA_WIDTH-1:0]    acc_data;
    logic [RATIO-1:0][S_KEEP_W-1:0]        acc_keep;
    logic [RATIO-1:0][S_DATA_WIDTH-1:0]    word_data;
    logic [RATIO-1:0][S_KEEP_W-1:0]        word_keep;

    logic [M_DATA_WIDTH-1:0]               data_p1;
    logic [M_KEEP_W-1:0]                   keep_p1;
    logic                                  last_p1;
    logic                                  vld_p1;

    out_state_t                            state;
    out_state_t                            state_next;

    logic                                  accept;
    logic                                  close;
    logic                                  pop;
    logic                                  last_lane;

    assign vld_p1    = (state == FULL);
    assign s.tready  = wrst_n & (~vld_p1 | m.tready);
    assign accept    = s.tvalid & s.tready;
    assign last_lane = (lane == LANE_W'(RATIO - 1));
    assign close     = accept & (last_lane | s.tlast);
    assign pop       = vld_p1 & m.tready;

    always_comb begin
        word_data = '0;
        word_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) < lane) begin
                word_data[i] = acc_data[i];
                word_keep[i] = acc_keep[i];
            end else if (LANE_W'(i) == lane) begin
                word_data[i] = s.tdata;
                word_keep[i] = s.tkeep;
            end
        end
    end

    // Stage p0: narrow beats collect in the accumulator until the word closes.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            lane     <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (close) begin
            lane     <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            acc_data[lane] <= s.tdata;
            acc_keep[lane] <= s.tkeep;
            lane           <= lane + LANE_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (close) state_next = FULL;
            FULL:    if (pop && !close) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) state <= EMPTY;
        else         state <= state_next;
    end

    // Stage p1: one-entry output register; a close can only happen when it is free or draining.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            data_p1 <= '0;
            keep_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (close) begin
            data_p1 <= word_data;
            keep_p1 <= word_keep;
            last_p1 <= s.tlast;
        end
    end

    assign m.tdata  = data_p1;
    assign m.tkeep  = keep_p1;
    assign m.tlast  = last_p1;
    assign m.tvalid = vld_p1;

`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)             pkt_cnt <= '0;
        else if (pop && last_p1) pkt_cnt <= pkt_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Scoreboard bench for axis_width_upsizer (S_DATA_WIDTH=8, RATIO=4).
module tb_axis_width_upsizer;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic wclk;
    logic wrst_n;
    int   n_cmp;
    int   n_err;
    int   pkt_seen;
    bit   rand_rdy;
    word_t exp_q[$];

    axis_width_upsizer_if #(.DATA_W(8))  s_if ();
    axis_width_upsizer_if #(.DATA_W(32)) m_if ();

`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
    logic [31:0] pkt_cnt;
`endif

    axis_width_upsizer #(
        .S_DATA_WIDTH (8),
        .RATIO        (4)
    ) dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .s       (s_if),
`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
        .pkt_cnt (pkt_cnt),
`endif
        .m       (m_if)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a transfer seen at the falling edge completes on the next rising edge.
    initial begin
        word_t w;
        forever begin
            @(negedge wclk);
            if (wrst_n && m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(m_if.tdata), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    w = exp_q.pop_front();
                    check("tdata", 64'(m_if.tdata), 64'(w.d));
                    check("tkeep", 64'(m_if.tkeep), 64'(w.k));
                    check("tlast", 64'(m_if.tlast), 64'(w.l));
                    if (w.l) pkt_seen++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        logic rdy;
        int   waited;
        waited      = 0;
        s_if.tdata  = d;
        s_if.tkeep  = 1'b1;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        forever begin
            @(negedge wclk);
            rdy = s_if.tready;
            @(posedge wclk);
            if (rdy) break;
            waited++;
            if (waited > 500) begin
                check("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back('{d, k, l});
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(negedge wclk);
            cyc++;
        end
        repeat (2) @(negedge wclk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge wclk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] md;
        logic [3:0]  mk;
        logic [7:0]  d;
        logic        last;
        int          ml;

        n_cmp       = 0;
        n_err       = 0;
        pkt_seen    = 0;
        rand_rdy    = 1'b0;
        wrst_n      = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        #1;
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        check("rst_m_tkeep",  64'(m_if.tkeep),  64'd0);
        check("rst_m_tlast",  64'(m_if.tlast),  64'd0);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        @(negedge wclk);
        check("release_s_tready", 64'(s_if.tready), 64'd1);
`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        @(posedge wclk);
        #1;

        // Two full words back to back.
        push(32'h4433_2211, 4'hF, 1'b0);
        push(32'h8877_6655, 4'hF, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i * 8'h11), i == 8);
            if (i == 4 || i == 8) begin
                check("latency_tvalid", 64'(m_if.tvalid), 64'd1);
                check("latency_tdata", 64'(m_if.tdata), (i == 4) ? 64'h4433_2211 : 64'h8877_6655);
            end
        end

        // Short packets flush early with partial keep.
        push(32'h00A3_A2A1, 4'h7, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        push(32'h0000_005C, 4'h1, 1'b1);
        send(8'h5C, 1'b1);
        drain();

        // Backpressure with a word held in the output register.
        m_if.tready = 1'b0;
        push(32'h0403_0201, 4'hF, 1'b0);
        push(32'h0807_0605, 4'hF, 1'b1);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        held = m_if.tdata;
        fork
            begin
                for (int i = 5; i <= 8; i++) send(8'(i), i == 8);
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge wclk);
                    check("stall_s_tready", 64'(s_if.tready), 64'd0);
                    check("stall_tdata_stable", 64'(m_if.tdata), 64'(held));
                end
                @(posedge wclk);
                #1;
                m_if.tready = 1'b1;
                @(negedge wclk);
                check("unstall_s_tready", 64'(s_if.tready), 64'd1);
            end
        join
        drain();

        // Random stream with random backpressure; packets end at beat 30 and 64.
        md = '0;
        mk = '0;
        ml = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d    = 8'($urandom_range(0, 255));
            last = (i == 29) || (i == 63);
            md[8*ml +: 8] = d;
            mk[ml]        = 1'b1;
            if (ml == 3 || last) begin
                push(md, mk, last);
                md = '0;
                mk = '0;
                ml = 0;
            end else begin
                ml++;
            end
            send(d, last);
        end
        rand_rdy    = 1'b0;
        m_if.tready = 1'b1;
        drain();
`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
        check("pkt_cnt_value", 64'(pkt_cnt), 64'(pkt_seen));
`endif

        // Reset mid-packet discards the partial word.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        wrst_n = 1'b0;
        @(negedge wclk);
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge wclk);
            check("postrst_no_tvalid", 64'(m_if.tvalid), 64'd0);
        end
`ifdef AXIS_WIDTH_UPSIZER_PKT_CNT_EN
        check("postrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        @(posedge wclk);
        #1;
        push(32'hD4D3_D2D1, 4'hF, 1'b1);
        for (int i = 1; i <= 4; i++) send(8'(8'hD0 + i), i == 4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
